// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU definitions: instruction-type codes, ALU opcodes and
// instruction field bit positions used by decode and execute.
package tinycpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Instruction types; 6..31 are reserved and behave as NOOP downstream
    localparam logic [4:0] TYPE_NOOP     = 5'd0;
    localparam logic [4:0] TYPE_LOAD_IMM = 5'd1;
    localparam logic [4:0] TYPE_LOAD     = 5'd2;
    localparam logic [4:0] TYPE_STORE    = 5'd3;
    localparam logic [4:0] TYPE_ALU_OP   = 5'd4;
    localparam logic [4:0] TYPE_JUMP     = 5'd5;

    // ALU opcodes; 11..31 are undefined
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SHL   = 5'd5;
    localparam logic [4:0] ALU_SHR   = 5'd6;
    localparam logic [4:0] ALU_NOT   = 5'd7;
    localparam logic [4:0] ALU_EQ    = 5'd8;
    localparam logic [4:0] ALU_LTU   = 5'd9;
    localparam logic [4:0] ALU_PASS0 = 5'd10;

    // Instruction field bit positions
    localparam int TYPE_MSB   = 31;
    localparam int TYPE_LSB   = 27;
    localparam int R0_MSB     = 26;
    localparam int R0_LSB     = 22;
    localparam int R1_MSB     = 21;
    localparam int R1_LSB     = 17;
    localparam int RES_MSB    = 16;
    localparam int RES_LSB    = 12;
    localparam int OP_MSB     = 11;
    localparam int OP_LSB     = 7;
    localparam int IMMREG_MSB = 10;
    localparam int IMMREG_LSB = 6;
    localparam int IMM_MSB    = 26;
    localparam int IMM_LSB    = 11;

endpackage

// File: rtl/decode_alu_datapath_if.sv
// Bundle of decode fields and execute-stage operands/results between the
// TinyCPU pipeline control (master) and the decode/ALU datapath (slave).
interface decode_alu_datapath_if;
    import tinycpu_pkg::*;

    logic [31:0] instruction;
    logic [4:0]  instruction_type;
    logic [4:0]  load_imm_reg;
    logic [31:0] load_imm_data;
    logic [4:0]  load_mem_addr_reg;
    logic [4:0]  load_mem_reg;
    logic [4:0]  store_data_reg;
    logic [4:0]  store_addr_reg;
    logic [4:0]  alu_op_reg_0;
    logic [4:0]  alu_op_reg_1;
    logic [4:0]  alu_op_reg_res;
    logic [4:0]  alu_operation;
    logic [4:0]  jump_condition_reg;
    logic [4:0]  jump_address_reg;
    logic [31:0] exe_instruction;
    logic [31:0] reg_value_0;
    logic [31:0] reg_value_1;
    logic [31:0] alu_out;
    logic [31:0] alu_result;
    logic [31:0] exe_instruction_q;

    modport master (
        output instruction, exe_instruction, reg_value_0, reg_value_1,
        input  instruction_type, load_imm_reg, load_imm_data,
               load_mem_addr_reg, load_mem_reg, store_data_reg, store_addr_reg,
               alu_op_reg_0, alu_op_reg_1, alu_op_reg_res, alu_operation,
               jump_condition_reg, jump_address_reg,
               alu_out, alu_result, exe_instruction_q
    );

    modport slave (
        input  instruction, exe_instruction, reg_value_0, reg_value_1,
        output instruction_type, load_imm_reg, load_imm_data,
               load_mem_addr_reg, load_mem_reg, store_data_reg, store_addr_reg,
               alu_op_reg_0, alu_op_reg_1, alu_op_reg_res, alu_operation,
               jump_condition_reg, jump_address_reg,
               alu_out, alu_result, exe_instruction_q
    );

endinterface

// File: rtl/decode_alu_datapath_units.sv
// Combinational building blocks of the decode/execute datapath:
// field decoder, ALU operand/opcode control and the ALU itself.

module basic_pipeline_decoder
    import tinycpu_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [4:0]  instruction_type,
    output logic [4:0]  load_imm_reg,
    output logic [31:0] load_imm_data,
    output logic [4:0]  load_mem_addr_reg,
    output logic [4:0]  load_mem_reg,
    output logic [4:0]  store_data_reg,
    output logic [4:0]  store_addr_reg,
    output logic [4:0]  alu_op_reg_0,
    output logic [4:0]  alu_op_reg_1,
    output logic [4:0]  alu_op_reg_res,
    output logic [4:0]  alu_operation,
    output logic [4:0]  jump_condition_reg,
    output logic [4:0]  jump_address_reg
);
    // Low six bits carry no field in any instruction format
    logic unused_low_bits;
    assign unused_low_bits = ^instruction[5:0];

    // Every field is driven for every type; consumers qualify by type
    assign instruction_type   = instruction[TYPE_MSB:TYPE_LSB];
    assign load_imm_reg       = instruction[IMMREG_MSB:IMMREG_LSB];
    assign load_imm_data      = {16'h0, instruction[IMM_MSB:IMM_LSB]};
    assign load_mem_addr_reg  = instruction[R0_MSB:R0_LSB];
    assign load_mem_reg       = instruction[R1_MSB:R1_LSB];
    assign store_data_reg     = instruction[R0_MSB:R0_LSB];
    assign store_addr_reg     = instruction[R1_MSB:R1_LSB];
    assign alu_op_reg_0       = instruction[R0_MSB:R0_LSB];
    assign alu_op_reg_1       = instruction[R1_MSB:R1_LSB];
    assign alu_op_reg_res     = instruction[RES_MSB:RES_LSB];
    assign alu_operation      = instruction[OP_MSB:OP_LSB];
    assign jump_condition_reg = instruction[R0_MSB:R0_LSB];
    assign jump_address_reg   = instruction[R1_MSB:R1_LSB];
endmodule

module alu_control
    import tinycpu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] reg_value_0,
    input  logic [31:0] reg_value_1,
    output logic [31:0] alu_in0,
    output logic [31:0] alu_in1,
    output logic [4:0]  op_select
);
    // Operand steering: NOT ignores in1; undefined ops collapse to 0+0
    always_comb begin
        alu_in0   = reg_value_0;
        alu_in1   = reg_value_1;
        op_select = op;
        if (op == ALU_NOT) begin
            alu_in1 = '0;
        end else if (op > ALU_PASS0) begin
            alu_in0   = '0;
            alu_in1   = '0;
            op_select = ALU_ADD;
        end
    end
endmodule

module alu
    import tinycpu_pkg::*;
(
    input  logic [31:0] alu_in0,
    input  logic [31:0] alu_in1,
    input  logic [4:0]  op_select,
    output logic [31:0] alu_out
);
    // Unsigned 32-bit operations; arithmetic wraps modulo 2^32
    always_comb begin
        alu_out = '0;
        case (op_select)
            ALU_ADD:   alu_out = alu_in0 + alu_in1;
            ALU_SUB:   alu_out = alu_in0 - alu_in1;
            ALU_AND:   alu_out = alu_in0 & alu_in1;
            ALU_OR:    alu_out = alu_in0 | alu_in1;
            ALU_XOR:   alu_out = alu_in0 ^ alu_in1;
            ALU_SHL:   alu_out = alu_in0 << alu_in1[4:0];
            ALU_SHR:   alu_out = alu_in0 >> alu_in1[4:0];
            ALU_NOT:   alu_out = ~alu_in0;
            ALU_EQ:    alu_out = {31'd0, alu_in0 == alu_in1};
            ALU_LTU:   alu_out = {31'd0, alu_in0 < alu_in1};
            ALU_PASS0: alu_out = alu_in0;
            default:   alu_out = '0;
        endcase
    end
endmodule

// File: rtl/decode_alu_datapath.sv
// TinyCPU decode fields plus execute-stage ALU, with the ALU result and the
// instruction registered into the execute/memory boundary.
module decode_alu_datapath
    import tinycpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    decode_alu_datapath_if.slave bus
);
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [4:0]  op_select;
    logic [31:0] alu_out_p0;
    logic [31:0] alu_result_p1;
    logic [31:0] exe_instruction_p1;

    basic_pipeline_decoder u_decoder (
        .instruction        (bus.instruction),
        .instruction_type   (bus.instruction_type),
        .load_imm_reg       (bus.load_imm_reg),
        .load_imm_data      (bus.load_imm_data),
        .load_mem_addr_reg  (bus.load_mem_addr_reg),
        .load_mem_reg       (bus.load_mem_reg),
        .store_data_reg     (bus.store_data_reg),
        .store_addr_reg     (bus.store_addr_reg),
        .alu_op_reg_0       (bus.alu_op_reg_0),
        .alu_op_reg_1       (bus.alu_op_reg_1),
        .alu_op_reg_res     (bus.alu_op_reg_res),
        .alu_operation      (bus.alu_operation),
        .jump_condition_reg (bus.jump_condition_reg),
        .jump_address_reg   (bus.jump_address_reg)
    );

    alu_control u_alu_control (
        .op          (bus.exe_instruction[OP_MSB:OP_LSB]),
        .reg_value_0 (bus.reg_value_0),
        .reg_value_1 (bus.reg_value_1),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .op_select   (op_select)
    );

    alu u_alu (
        .alu_in0   (alu_in0),
        .alu_in1   (alu_in1),
        .op_select (op_select),
        .alu_out   (alu_out_p0)
    );

    // ---- execute / memory boundary ----
    // Capture result and instruction every cycle; reset drops in-flight work
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_p1      <= '0;
            exe_instruction_p1 <= '0;
        end else begin
            alu_result_p1      <= alu_out_p0;
            exe_instruction_p1 <= bus.exe_instruction;
        end
    end

    assign bus.alu_out           = alu_out_p0;
    assign bus.alu_result        = alu_result_p1;
    assign bus.exe_instruction_q = exe_instruction_p1;
endmodule

// File: tb/tb_decode_alu_datapath.sv
// Directed bench for decode_alu_datapath: field decode, ALU op sweep,
// register latency, asynchronous reset and bubble handling.
module tb_decode_alu_datapath;
    import tinycpu_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    decode_alu_datapath_if bus ();

    decode_alu_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] alu_instr(input logic [4:0] op);
        return {5'd4, 5'd0, 5'd0, 5'd0, op, 7'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu_case(input string tag, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        bus.exe_instruction = alu_instr(op);
        bus.reg_value_0     = a;
        bus.reg_value_1     = b;
        #1;
        check(tag, bus.alu_out, exp);
    endtask

    initial begin
        logic [31:0] add_instr;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.instruction     = '0;
        bus.exe_instruction = alu_instr(ALU_ADD);
        bus.reg_value_0     = 32'd5;
        bus.reg_value_1     = 32'd7;

        // Reset state, held across a clock edge while rst is low
        #2;
        check("rst_alu_result", bus.alu_result, 32'h0);
        check("rst_exe_q", bus.exe_instruction_q, 32'h0);
        @(posedge clk); #1;
        check("rst_hold_alu_result", bus.alu_result, 32'h0);
        check("rst_hold_exe_q", bus.exe_instruction_q, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Decode of an ALU_OP instruction
        bus.instruction = {5'd4, 5'd3, 5'd2, 5'd7, 5'd0, 7'd0};
        #1;
        check("dec_type", {27'd0, bus.instruction_type}, 32'd4);
        check("dec_op_reg_0", {27'd0, bus.alu_op_reg_0}, 32'd3);
        check("dec_op_reg_1", {27'd0, bus.alu_op_reg_1}, 32'd2);
        check("dec_op_reg_res", {27'd0, bus.alu_op_reg_res}, 32'd7);
        check("dec_operation", {27'd0, bus.alu_operation}, 32'd0);
        check("dec_mem_addr_reg", {27'd0, bus.load_mem_addr_reg}, 32'd3);
        check("dec_store_addr_reg", {27'd0, bus.store_addr_reg}, 32'd2);
        check("dec_jump_cond_reg", {27'd0, bus.jump_condition_reg}, 32'd3);

        // Decode of a LOAD_IMM instruction
        bus.instruction = {5'd1, 16'hBEEF, 5'd9, 6'd0};
        #1;
        check("imm_type", {27'd0, bus.instruction_type}, 32'd1);
        check("imm_data", bus.load_imm_data, 32'h0000_BEEF);
        check("imm_reg", {27'd0, bus.load_imm_reg}, 32'd9);

        // ALU sweep with all-ones and one
        alu_case("alu_add_wrap", ALU_ADD,   32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        alu_case("alu_sub",      ALU_SUB,   32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE);
        alu_case("alu_and",      ALU_AND,   32'hFFFF_FFFF, 32'd1, 32'h0000_0001);
        alu_case("alu_or",       ALU_OR,    32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        alu_case("alu_xor",      ALU_XOR,   32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE);
        alu_case("alu_shl",      ALU_SHL,   32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE);
        alu_case("alu_shr",      ALU_SHR,   32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF);
        alu_case("alu_not",      ALU_NOT,   32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        alu_case("alu_eq_ne",    ALU_EQ,    32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        alu_case("alu_ltu_ge",   ALU_LTU,   32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        alu_case("alu_pass0",    ALU_PASS0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        alu_case("alu_op20",     5'd20,     32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        alu_case("alu_op11",     5'd11,     32'h0000_0003, 32'd4, 32'h0000_0000);

        // Further patterns: true compares, NOT pattern, shift amount masking
        alu_case("alu_eq_eq",    ALU_EQ,    32'd5,         32'd5,  32'd1);
        alu_case("alu_ltu_lt",   ALU_LTU,   32'd3,         32'd9,  32'd1);
        alu_case("alu_not_pat",  ALU_NOT,   32'h0F0F_0F0F, 32'd77, 32'hF0F0_F0F0);
        alu_case("alu_shl_mask", ALU_SHL,   32'd1,         32'd33, 32'd2);
        alu_case("alu_sub_wrap", ALU_SUB,   32'd0,         32'd1,  32'hFFFF_FFFF);

        // Latency: ADD 5+7 registered on the next edge
        @(negedge clk);
        add_instr = {5'd4, 5'd1, 5'd2, 5'd3, ALU_ADD, 7'd0};
        bus.exe_instruction = add_instr;
        bus.reg_value_0     = 32'd5;
        bus.reg_value_1     = 32'd7;
        #1;
        check("lat_alu_out", bus.alu_out, 32'd12);
        @(posedge clk); #1;
        check("lat_alu_result", bus.alu_result, 32'd12);
        check("lat_exe_q", bus.exe_instruction_q, add_instr);

        // Asynchronous reset mid-cycle clears registers before the next edge
        #2;
        rst = 1'b0;
        #1;
        check("arst_alu_result", bus.alu_result, 32'h0);
        check("arst_exe_q", bus.exe_instruction_q, 32'h0);
        check("arst_comb_alu_out", bus.alu_out, 32'd12);
        @(posedge clk); #1;
        check("arst_hold_alu_result", bus.alu_result, 32'h0);
        check("arst_hold_exe_q", bus.exe_instruction_q, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Bubble: NOOP instruction still produces an ADD of the operands
        bus.exe_instruction = 32'h0;
        bus.reg_value_0     = 32'd100;
        bus.reg_value_1     = 32'd23;
        @(posedge clk); #1;
        check("bubble_exe_q", bus.exe_instruction_q, 32'h0);
        check("bubble_alu_result", bus.alu_result, 32'd123);

        // Back-to-back captures follow the inputs each cycle
        @(negedge clk);
        bus.exe_instruction = alu_instr(ALU_XOR);
        bus.reg_value_0     = 32'hA5A5_0000;
        bus.reg_value_1     = 32'h0000_5A5A;
        @(posedge clk); #1;
        check("b2b_1_result", bus.alu_result, 32'hA5A5_5A5A);
        @(negedge clk);
        bus.exe_instruction = alu_instr(ALU_SHR);
        bus.reg_value_0     = 32'h8000_0000;
        bus.reg_value_1     = 32'd31;
        @(posedge clk); #1;
        check("b2b_2_result", bus.alu_result, 32'd1);
        check("b2b_2_exe_q", bus.exe_instruction_q, alu_instr(ALU_SHR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_alu_datapath.md
# decode_alu_datapath

Combinational instruction decoder plus execute-stage ALU datapath for the 5-stage pipelined TinyCPU. Decode half splits the issue-register instruction into type and register/immediate fields for register-file control. Execute half selects ALU operands from the end-of-decode instruction and registered operands, computes the result, and registers the result and the instruction into the execute/memory boundary. Built from three sub-blocks: `basic_pipeline_decoder`, `alu_control`, `alu`.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register indices and opcodes).
- clk  in  1  clock; reset rst, asynchronous, active-low
- rst  in  1  asynchronous active-low reset
- instruction  in  32  issue-register instruction (decode stage)
- instruction_type  out  5  = instruction[31:27]
- load_imm_reg  out  5  = instruction[10:6]
- load_imm_data  out  32  = {16'h0, instruction[26:11]}
- load_mem_addr_reg / load_mem_reg  out  5 each  = [26:22] / [21:17]
- store_data_reg / store_addr_reg  out  5 each  = [26:22] / [21:17]
- alu_op_reg_0 / alu_op_reg_1 / alu_op_reg_res  out  5 each  = [26:22] / [21:17] / [16:12]
- alu_operation  out  5  = instruction[11:7]
- jump_condition_reg / jump_address_reg  out  5 each  = [26:22] / [21:17]
- exe_instruction  in  32  end-of-decode instruction register value
- reg_value_0 / reg_value_1  in  32 each  registered register-file read data
- alu_out  out  32  combinational ALU result
- alu_result  out  32  registered ALU result
- exe_instruction_q  out  32  registered exe_instruction (end-of-execute instruction)

## Operation
- Instruction types: NOOP=0, LOAD_IMM=1, LOAD=2, STORE=3, ALU_OP=4, JUMP=5; 6–31 reserved, behave as NOOP downstream. 32'h0 is the canonical bubble.
- Decoder purely combinational; all field outputs driven for every type (no gating by type).
- alu_control: op = exe_instruction[11:7]; alu_in0 = reg_value_0, alu_in1 = reg_value_1, op_select = op; for NOT, alu_in1 forced 0; undefined op (11–31) -> op_select ADD with both inputs 0.
- ALU ops: ADD=0 (in0+in1, mod 2^32), SUB=1 (in0−in1, wraps), AND=2, OR=3, XOR=4, SHL=5 (in0 << in1[4:0]), SHR=6 (logical, in0 >> in1[4:0]), NOT=7 (~in0), EQ=8 (32'd1 if equal else 0), LTU=9 (32'd1 if in0<in1 unsigned else 0), PASS0=10 (in0). Any other op_select -> 0.
- ALU computes regardless of instruction type; consumers qualify by type.

## Timing
- Decode outputs and alu_out: zero-cycle combinational.
- alu_result, exe_instruction_q: 1-cycle latency, update every posedge clk (no enable; stalls inject bubbles upstream).
- rst low: alu_result = 0, exe_instruction_q = 0 immediately, held while low; first capture on first posedge after rst high.
- Reset mid-operation discards in-flight result; combinational outputs unaffected by rst.

## Structure
- Shared package `tinycpu_pkg`: instruction-type codes, ALU opcode codes, field bit positions (TYPE 31:27, R0 26:22, R1 21:17, RES 16:12, OP 11:7, IMMREG 10:6, IMM 26:11).
- Sub-modules: `basic_pipeline_decoder` (comb), `alu_control` (comb), `alu` (comb); top adds two 32-bit async-reset registers.

## Test plan
- Decode: instruction = {5'd4, 5'd3, 5'd2, 5'd7, 5'd0, 7'd0} -> type 4, alu_op_reg_0 3, alu_op_reg_1 2, alu_op_reg_res 7, alu_operation 0.
- Load imm: {5'd1, 16'hBEEF, 5'd9, 6'd0} -> load_imm_data 32'h0000BEEF, load_imm_reg 9.
- ALU sweep: reg_value_0=32'hFFFF_FFFF, reg_value_1=1; ADD -> 0, SUB -> FFFF_FFFE, SHL -> FFFF_FFFE, SHR -> 7FFF_FFFF, NOT -> 0, EQ -> 0, LTU -> 0; op 20 -> 0.
- Latency: apply ADD 5+7 at cycle n -> alu_out 12 same cycle, alu_result 12 and exe_instruction_q equal to input after posedge n.
- Reset: drive rst low asynchronously mid-cycle with alu_result=12 -> alu_result and exe_instruction_q 0 before next edge, stay 0 until rst high.
- Bubble: exe_instruction 32'h0 with any operands -> exe_instruction_q 0 next cycle, alu_result = reg_value_0+reg_value_1.
